mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter ADDR_STEP, default 3'd4, the PC increment applied via ALUSrcB=10 in FETCH.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port Instr, input, [25:10], the latched instruction: [25] cond-on-Z, [24:23] Op, [22:18] Funct (I,cmd[2:0],S/L), [17:14] Rd.
REQ-005 SHALL have port ALUFlags, input, 4, {N,Z,C,V} from the ALU.
REQ-006 SHALL have port mem_ready, input, 1, the memory access-complete strobe.
REQ-007 SHALL have outputs PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, each 1 bit, the datapath enables and address select.
REQ-008 SHALL have outputs ResultSrc, ALUSrcA, ALUSrcB, ImmSrc and RegSrc, each 2 bits, and ALUControl, 3 bits.
REQ-009 SHALL have outputs state_o, 4 bits, the current state, and illegal_o, 1 bit, a one-cycle pulse.

Function
REQ-010 SHALL implement the states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8 and BRANCH=9; encodings 10-15 SHALL go to FETCH on the next edge.
REQ-011 SHALL sequence FETCH->DECODE unconditionally (without wait states).
REQ-012 SHALL sequence DECODE by Op: 00->EXECR if Funct[4]=0 else EXECI; 01->MEMADR; 10->BRANCH; 11->FETCH with illegal_o=1 for that cycle.
REQ-013 SHALL sequence MEMADR->MEMRD if Funct[0]=1 else MEMWR; MEMRD->MEMWB->FETCH; MEMWR->FETCH; EXECR/EXECI->ALUWB->FETCH; BRANCH->FETCH.
REQ-014 SHALL take 4 cycles for DP, 5 for LDR, 4 for STR and 3 for B per instruction with zero wait states.
REQ-015 SHALL drive in FETCH: AdrSrc=0, IRWrite=1, PCWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUControl=000.
REQ-016 SHALL drive in DECODE: ALUSrcA=01, ALUSrcB=10, ALUControl=000, with ImmSrc/RegSrc decoded from Op (DP 00/00, MEM 01/10, B 10/01).
REQ-017 SHALL drive in MEMADR: ALUSrcA=00, ALUSrcB=01, ALUControl=000.
REQ-018 SHALL drive AdrSrc=1 in MEMRD and MEMWR, and SHALL assert MemWrite in MEMWR only when the condition passes.
REQ-019 SHALL drive in MEMWB: ResultSrc=01 and RegWrite=condition.
REQ-020 SHALL drive in EXECR/EXECI: ALUSrcB=00 or 01 respectively, and ALUControl=cmd, except cmd=100 (CMP), which SHALL drive 001.
REQ-021 SHALL drive in ALUWB: ResultSrc=00 and RegWrite=condition AND cmd!=100.
REQ-022 SHALL drive in BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10 and PCWrite=condition.
REQ-023 SHALL define condition = 1 when Instr[25]=0, and the saved Z flag when Instr[25]=1.
REQ-024 SHALL update the flag register from ALUFlags at the end of EXECR/EXECI when Funct[0]=1 (or cmd=100) and the condition passes.
REQ-025 SHALL evaluate condition against the old flags when a flag update coincides with the evaluation.
REQ-026 SHALL hold every output not listed for a state at 0.
REQ-027 SHALL make all outputs pure decodes of the state, Instr and flags, with no extra latency.

Reset
REQ-028 SHALL, on reset=0, immediately force state=FETCH, flags=0000 and illegal_o=0, regardless of clk.
REQ-029 SHALL, when reset asserts mid-instruction, abandon that instruction with no further RegWrite or MemWrite.
REQ-030 SHALL start fetching on the first rising clk edge after reset deasserts.

Configuration
REQ-031 SHALL, when MC_CONTROLLER_MEM_WAIT_EN is defined, hold FETCH, MEMRD and MEMWR until mem_ready=1.
REQ-032 SHALL, under MC_CONTROLLER_MEM_WAIT_EN, pulse IRWrite/PCWrite in FETCH and MemWrite in MEMWR only in the mem_ready=1 cycle.
REQ-033 SHALL, when MC_CONTROLLER_MEM_WAIT_EN is undefined, ignore mem_ready and treat memory as single-cycle.

Verification
REQ-034 SHALL cover: ADD r1 (Op=00, I=0, cmd=000, S=0, Instr[25]=0) -> states 0,1,6,8,0; RegWrite=1 only in cycle 4.
REQ-035 SHALL cover: CMP with ALUFlags=0100, then a conditional STR (Instr[25]=1) -> MemWrite=1 in MEMWR; repeated with ALUFlags=0000 -> MemWrite=0.
REQ-036 SHALL cover: LDR (Op=01, L=1) -> states 0,1,2,3,4,0 with AdrSrc=1 in MEMRD and ResultSrc=01 with RegWrite=1 in MEMWB.
REQ-037 SHALL cover: Op=11 -> illegal_o=1 for exactly one cycle in DECODE, then FETCH, with no write enables asserted.
REQ-038 SHALL cover: reset=0 asserted in MEMWR between clock edges -> state_o=0 and MemWrite=0 immediately, without a clock edge.
REQ-039 SHALL cover, with MC_CONTROLLER_MEM_WAIT_EN: mem_ready low for 3 cycles in FETCH -> state_o holds 0 and IRWrite=0, then IRWrite=1 for one cycle.

Source files
------------

// File: rtl/mc_controller.sv
// mc_controller: multicycle control FSM for a small ARM-like datapath, with a saved NZCV flag register.
// Optional MC_CONTROLLER_MEM_WAIT_EN: FETCH, MEMRD and MEMWR stall until mem_ready.
module mc_controller #(
    parameter logic [2:0] ADDR_STEP = 3'd4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [25:10] Instr,
    input  logic [3:0]   ALUFlags,
    input  logic         mem_ready,
    output logic         PCWrite,
    output logic         IRWrite,
    output logic         RegWrite,
    output logic         MemWrite,
    output logic         AdrSrc,
    output logic [1:0]   ResultSrc,
    output logic [1:0]   ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ImmSrc,
    output logic [1:0]   RegSrc,
    output logic [2:0]   ALUControl,
    output logic [3:0]   state_o,
    output logic         illegal_o
);

    localparam int unsigned STATE_W = 4;
    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned Z_BIT   = 2;

    typedef enum logic [STATE_W-1:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [FLAG_W-1:0]   flags;
    logic                flag_upd;
    logic                mem_go;
    logic                unused_bits;

    logic [1:0] op;
    logic       i_bit;
    logic [2:0] cmd;
    logic       s_bit;
    logic       is_cmp;
    logic       cond;

    // Instruction field decode; cond always sees the flags saved before this cycle's edge.
    assign op     = Instr[24:23];
    assign i_bit  = Instr[22];
    assign cmd    = Instr[21:19];
    assign s_bit  = Instr[18];
    assign is_cmp = (cmd == 3'b100);
    assign cond   = ~Instr[25] | flags[Z_BIT];

`ifdef MC_CONTROLLER_MEM_WAIT_EN
    assign mem_go      = mem_ready;
    assign unused_bits = ^{ADDR_STEP, Instr[17:10], flags[3], flags[1:0]};
`else
    assign mem_go      = 1'b1;
    assign unused_bits = ^{ADDR_STEP, Instr[17:10], flags[3], flags[1:0], mem_ready};
`endif

    // State and flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            flags <= '0;
        end else begin
            state <= state_nxt;
            if (flag_upd) begin
                flags <= ALUFlags;
            end
        end
    end

    assign state_o = state;

    // Next-state and datapath control decode.
    always_comb begin
        state_nxt  = FETCH;
        flag_upd   = 1'b0;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        ALUControl = 3'b000;
        illegal_o  = 1'b0;

        case (state)
            FETCH: begin
                IRWrite   = mem_go;
                PCWrite   = mem_go;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_nxt = mem_go ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                case (op)
                    2'b00: begin
                        state_nxt = i_bit ? EXECI : EXECR;
                    end
                    2'b01: begin
                        ImmSrc    = 2'b01;
                        RegSrc    = 2'b10;
                        state_nxt = MEMADR;
                    end
                    2'b10: begin
                        ImmSrc    = 2'b10;
                        RegSrc    = 2'b01;
                        state_nxt = BRANCH;
                    end
                    default: begin
                        illegal_o = 1'b1;
                        state_nxt = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcB   = 2'b01;
                state_nxt = s_bit ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc    = 1'b1;
                state_nxt = mem_go ? MEMWB : MEMRD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = cond;
                state_nxt = FETCH;
            end
            MEMWR: begin
                AdrSrc    = 1'b1;
                MemWrite  = cond & mem_go;
                state_nxt = mem_go ? FETCH : MEMWR;
            end
            EXECR, EXECI: begin
                ALUSrcB    = (state == EXECI) ? 2'b01 : 2'b00;
                ALUControl = is_cmp ? 3'b001 : cmd;
                flag_upd   = (s_bit | is_cmp) & cond;
                state_nxt  = ALUWB;
            end
            ALUWB: begin
                RegWrite  = cond & ~is_cmp;
                state_nxt = FETCH;
            end
            BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond;
                state_nxt = FETCH;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller; expected control vectors are written out per state.
module tb_mc_controller;

    logic         clk;
    logic         reset;
    logic [25:10] Instr;
    logic [3:0]   ALUFlags;
    logic         mem_ready;
    logic         PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
    logic [1:0]   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0]   ALUControl;
    logic [3:0]   state_o;
    logic         illegal_o;
    logic [18:0]  outs;

    int checks = 0;
    int errors = 0;

    mc_controller #(.ADDR_STEP(3'd4)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .state_o(state_o), .illegal_o(illegal_o)
    );

    // {PCWrite,IRWrite,RegWrite,MemWrite,AdrSrc, ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,RegSrc, ALUControl, illegal_o}
    assign outs = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
                   ImmSrc, RegSrc, ALUControl, illegal_o};

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                           S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
                           S_ALUWB = 4'd8, S_BRANCH = 4'd9;

    localparam logic [18:0] X_FETCH     = {5'b11000, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [18:0] X_DEC_DP    = {5'b00000, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [18:0] X_DEC_MEM   = {5'b00000, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 3'b000, 1'b0};
    localparam logic [18:0] X_DEC_B     = {5'b00000, 2'b00, 2'b01, 2'b10, 2'b10, 2'b01, 3'b000, 1'b0};
    localparam logic [18:0] X_DEC_ILL   = {5'b00000, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000, 1'b1};
    localparam logic [18:0] X_MEMADR    = {5'b00000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [18:0] X_MEMRD     = {5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [18:0] X_MEMWR_W   = {5'b00011, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [18:0] X_MEMWR_N   = {5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [18:0] X_MEMWB_W   = {5'b00100, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [18:0] X_EXECR_ADD = {5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [18:0] X_EXECR_CMP = {5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 1'b0};
    localparam logic [18:0] X_EXECI_SUB = {5'b00000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam logic [18:0] X_ALUWB_W   = {5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [18:0] X_ALUWB_N   = {5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [18:0] X_BRANCH_T  = {5'b10000, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [18:0] X_BRANCH_N  = {5'b00000, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0};

    // Instr[25:10] = {cond_z, Op, I, cmd, S/L, Rd=1, 4'b0}
    function automatic logic [15:0] mk(input logic c, input logic [1:0] op, input logic i,
                                       input logic [2:0] cmd, input logic s);
        return {c, op, i, cmd, s, 4'd1, 4'd0};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected $finish earlier");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset;
        reset = 1'b1; Instr = '0; ALUFlags = '0; mem_ready = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (state_o !== S_FETCH) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_o, S_FETCH); end
        checks++;
        if (outs !== X_FETCH) begin errors++; $display("FAIL reset_outs: got %05h expected %05h", outs, X_FETCH); end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (state_o !== S_FETCH) begin errors++; $display("FAIL reset_hold: got %0d expected %0d", state_o, S_FETCH); end
        reset = 1'b1;
        #1;
        checks++;
        if (state_o !== S_FETCH) begin errors++; $display("FAIL reset_release: got %0d expected %0d", state_o, S_FETCH); end
    endtask

    task automatic test_add;
        logic [3:0]  st [5];
        logic [18:0] ex [5];
        st = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_FETCH};
        ex = '{X_FETCH, X_DEC_DP, X_EXECR_ADD, X_ALUWB_W, X_FETCH};
        Instr = mk(1'b0, 2'b00, 1'b0, 3'b000, 1'b0); ALUFlags = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            checks++;
            if (state_o !== st[i]) begin errors++; $display("FAIL add_state[%0d]: got %0d expected %0d", i, state_o, st[i]); end
            checks++;
            if (outs !== ex[i]) begin errors++; $display("FAIL add_outs[%0d]: got %05h expected %05h", i, outs, ex[i]); end
        end
    endtask

    task automatic test_ldr;
        logic [3:0]  st [6];
        logic [18:0] ex [6];
        st = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_FETCH};
        ex = '{X_FETCH, X_DEC_MEM, X_MEMADR, X_MEMRD, X_MEMWB_W, X_FETCH};
        Instr = mk(1'b0, 2'b01, 1'b0, 3'b000, 1'b1); ALUFlags = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            checks++;
            if (state_o !== st[i]) begin errors++; $display("FAIL ldr_state[%0d]: got %0d expected %0d", i, state_o, st[i]); end
            checks++;
            if (outs !== ex[i]) begin errors++; $display("FAIL ldr_outs[%0d]: got %05h expected %05h", i, outs, ex[i]); end
        end
    endtask

    task automatic test_illegal;
        logic [3:0]  st [3];
        logic [18:0] ex [3];
        st = '{S_FETCH, S_DECODE, S_FETCH};
        ex = '{X_FETCH, X_DEC_ILL, X_FETCH};
        Instr = mk(1'b0, 2'b11, 1'b0, 3'b000, 1'b0); ALUFlags = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            checks++;
            if (state_o !== st[i]) begin errors++; $display("FAIL illegal_state[%0d]: got %0d expected %0d", i, state_o, st[i]); end
            checks++;
            if (outs !== ex[i]) begin errors++; $display("FAIL illegal_outs[%0d]: got %05h expected %05h", i, outs, ex[i]); end
        end
    endtask

    // CMP loads flags, then STR conditional on Z; ALUFlags is zeroed during the STR.
    task automatic test_cond_store(input logic [3:0] cmp_flags, input logic exp_wr);
        logic [3:0]  st [9];
        logic [18:0] ex [9];
        st = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_FETCH};
        ex = '{X_FETCH, X_DEC_DP, X_EXECR_CMP, X_ALUWB_N, X_FETCH, X_DEC_MEM, X_MEMADR,
               exp_wr ? X_MEMWR_W : X_MEMWR_N, X_FETCH};
        for (int i = 0; i < 9; i++) begin
            if (i != 0) @(negedge clk);
            Instr    = (i < 4) ? mk(1'b0, 2'b00, 1'b0, 3'b100, 1'b0) : mk(1'b1, 2'b01, 1'b0, 3'b000, 1'b0);
            ALUFlags = (i < 4) ? cmp_flags : 4'b0000;
            #1;
            checks++;
            if (state_o !== st[i]) begin errors++; $display("FAIL cstr_state[%0d]: got %0d expected %0d", i, state_o, st[i]); end
            checks++;
            if (outs !== ex[i]) begin errors++; $display("FAIL cstr_outs[%0d] flags=%b: got %05h expected %05h", i, cmp_flags, outs, ex[i]); end
        end
    endtask

    // Conditional CMP while Z=0 presents Z=1: old Z fails the condition, so no update.
    task automatic test_flag_timing;
        logic [3:0]  st [9];
        logic [18:0] ex [9];
        st = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_FETCH};
        ex = '{X_FETCH, X_DEC_DP, X_EXECR_CMP, X_ALUWB_N, X_FETCH, X_DEC_MEM, X_MEMADR, X_MEMWR_N, X_FETCH};
        for (int i = 0; i < 9; i++) begin
            if (i != 0) @(negedge clk);
            Instr    = (i < 4) ? mk(1'b1, 2'b00, 1'b0, 3'b100, 1'b0) : mk(1'b1, 2'b01, 1'b0, 3'b000, 1'b0);
            ALUFlags = (i < 4) ? 4'b0100 : 4'b0000;
            #1;
            checks++;
            if (state_o !== st[i]) begin errors++; $display("FAIL ftime_state[%0d]: got %0d expected %0d", i, state_o, st[i]); end
            checks++;
            if (outs !== ex[i]) begin errors++; $display("FAIL ftime_outs[%0d]: got %05h expected %05h", i, outs, ex[i]); end
        end
    endtask

    // Immediate op with S=1 sets Z, then a conditional STR must write.
    task automatic test_execi;
        logic [3:0]  st [9];
        logic [18:0] ex [9];
        st = '{S_FETCH, S_DECODE, S_EXECI, S_ALUWB, S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_FETCH};
        ex = '{X_FETCH, X_DEC_DP, X_EXECI_SUB, X_ALUWB_W, X_FETCH, X_DEC_MEM, X_MEMADR, X_MEMWR_W, X_FETCH};
        for (int i = 0; i < 9; i++) begin
            if (i != 0) @(negedge clk);
            Instr    = (i < 4) ? mk(1'b0, 2'b00, 1'b1, 3'b010, 1'b1) : mk(1'b1, 2'b01, 1'b0, 3'b000, 1'b0);
            ALUFlags = (i < 4) ? 4'b0100 : 4'b0000;
            #1;
            checks++;
            if (state_o !== st[i]) begin errors++; $display("FAIL execi_state[%0d]: got %0d expected %0d", i, state_o, st[i]); end
            checks++;
            if (outs !== ex[i]) begin errors++; $display("FAIL execi_outs[%0d]: got %05h expected %05h", i, outs, ex[i]); end
        end
    endtask

    task automatic test_branch(input logic taken);
        logic [3:0]  st [4];
        logic [18:0] ex [4];
        st = '{S_FETCH, S_DECODE, S_BRANCH, S_FETCH};
        ex = '{X_FETCH, X_DEC_B, taken ? X_BRANCH_T : X_BRANCH_N, X_FETCH};
        Instr = mk(1'b1, 2'b10, 1'b0, 3'b000, 1'b0); ALUFlags = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            checks++;
            if (state_o !== st[i]) begin errors++; $display("FAIL br_state[%0d]: got %0d expected %0d", i, state_o, st[i]); end
            checks++;
            if (outs !== ex[i]) begin errors++; $display("FAIL br_outs[%0d] taken=%0b: got %05h expected %05h", i, taken, outs, ex[i]); end
        end
    endtask

    // Reset asserted between edges while in MEMWR with Z=1.
    task automatic test_reset_mid_store;
        logic [3:0]  st [4];
        logic [18:0] ex [4];
        st = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR};
        ex = '{X_FETCH, X_DEC_MEM, X_MEMADR, X_MEMWR_W};
        Instr = mk(1'b1, 2'b01, 1'b0, 3'b000, 1'b0); ALUFlags = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            checks++;
            if (state_o !== st[i]) begin errors++; $display("FAIL rmid_state[%0d]: got %0d expected %0d", i, state_o, st[i]); end
            checks++;
            if (outs !== ex[i]) begin errors++; $display("FAIL rmid_outs[%0d]: got %05h expected %05h", i, outs, ex[i]); end
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (state_o !== S_FETCH) begin errors++; $display("FAIL rmid_async_state: got %0d expected %0d", state_o, S_FETCH); end
        checks++;
        if (MemWrite !== 1'b0) begin errors++; $display("FAIL rmid_async_memwrite: got %b expected 0", MemWrite); end
        checks++;
        if (outs !== X_FETCH) begin errors++; $display("FAIL rmid_async_outs: got %05h expected %05h", outs, X_FETCH); end
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (state_o !== S_FETCH) begin errors++; $display("FAIL rmid_release: got %0d expected %0d", state_o, S_FETCH); end
    endtask

`ifdef MC_CONTROLLER_MEM_WAIT_EN
    task automatic test_mem_wait;
        logic [3:0] st [4];
        Instr = mk(1'b0, 2'b00, 1'b0, 3'b000, 1'b0); ALUFlags = 4'b0000; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            checks++;
            if (state_o !== S_FETCH) begin errors++; $display("FAIL wait_state[%0d]: got %0d expected %0d", i, state_o, S_FETCH); end
            checks++;
            if ({IRWrite, PCWrite} !== 2'b00) begin errors++; $display("FAIL wait_irw[%0d]: got %b expected 00", i, {IRWrite, PCWrite}); end
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        checks++;
        if (state_o !== S_FETCH) begin errors++; $display("FAIL wait_ready_state: got %0d expected %0d", state_o, S_FETCH); end
        checks++;
        if ({IRWrite, PCWrite} !== 2'b11) begin errors++; $display("FAIL wait_ready_irw: got %b expected 11", {IRWrite, PCWrite}); end
        st = '{S_DECODE, S_EXECR, S_ALUWB, S_FETCH};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (state_o !== st[i]) begin errors++; $display("FAIL wait_seq[%0d]: got %0d expected %0d", i, state_o, st[i]); end
            if (i == 0) begin
                checks++;
                if (IRWrite !== 1'b0) begin errors++; $display("FAIL wait_irw_once: got %b expected 0", IRWrite); end
            end
        end
    endtask
`else
    // mem_ready held low must not stall a single-cycle memory build.
    task automatic test_no_wait;
        logic [3:0]  st [5];
        logic [18:0] ex [5];
        st = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_FETCH};
        ex = '{X_FETCH, X_DEC_DP, X_EXECR_ADD, X_ALUWB_W, X_FETCH};
        Instr = mk(1'b0, 2'b00, 1'b0, 3'b000, 1'b0); ALUFlags = 4'b0000; mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            checks++;
            if (state_o !== st[i]) begin errors++; $display("FAIL nowait_state[%0d]: got %0d expected %0d", i, state_o, st[i]); end
            checks++;
            if (outs !== ex[i]) begin errors++; $display("FAIL nowait_outs[%0d]: got %05h expected %05h", i, outs, ex[i]); end
        end
        mem_ready = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_ldr();
        test_illegal();
        test_cond_store(4'b0100, 1'b1);
        test_cond_store(4'b0000, 1'b0);
        test_flag_timing();
        test_execi();
        test_branch(1'b1);
        test_reset_mid_store();
        test_branch(1'b0);
`ifdef MC_CONTROLLER_MEM_WAIT_EN
        test_mem_wait();
`else
        test_no_wait();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
